// File: rtl/vgaram_pkg.sv
// Shared definitions for the video RAM arbiter: FSM state encoding and
// default bus widths.
package vgaram_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_CYCLE = 2'd1,
        ACK       = 2'd2
    } state_t;

endpackage : vgaram_pkg

// File: rtl/vgaram_arbiter.sv
// Single-port video RAM arbiter: VGA reads pass straight through, CPU accesses
// are slotted into cycles the VGA master has announced it will not use.
module vgaram_arbiter
    import vgaram_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic [AW-1:0] i_vga_addr,
    input  logic          i_vga_cs,
    input  logic          i_vga_access,
    output logic [DW-1:0] o_vga_dat,

    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dat,
    input  logic          i_cpu_cs,
    input  logic          i_cpu_we,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_cpu_ack,

    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_dat,
    output logic          o_ram_cs,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dat,

    output logic          o_conflict
);

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_dat;
    logic          hold_we;
    logic [DW-1:0] cpu_dat_q;
    logic          conflict_q;
    logic          cpu_start;

    // A CPU slot is only safe when the VGA master has not claimed next cycle.
    assign cpu_start = (state == IDLE) && i_cpu_cs && !i_vga_access;

    // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cpu_start) state_next = CPU_CYCLE;
            CPU_CYCLE: state_next = ACK;
            ACK:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Holding registers make the CPU side fully registered toward the RAM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_addr <= '0;
            hold_dat  <= '0;
            hold_we   <= 1'b0;
        end else if (cpu_start) begin
            hold_addr <= i_cpu_addr;
            hold_dat  <= i_cpu_dat;
            hold_we   <= i_cpu_we;
        end
    end

    // Read data is held between acks; a write ack leaves it untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset)                          cpu_dat_q <= '0;
        else if ((state == ACK) && !hold_we)  cpu_dat_q <= i_ram_dat;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)                               conflict_q <= 1'b0;
        else if ((state == CPU_CYCLE) && i_vga_cs) conflict_q <= 1'b1;
    end

    // RAM port mux, selected only by registered state to keep VGA latency flat.
    always_comb begin
        o_ram_addr = i_vga_addr;
        o_ram_dat  = '0;
        o_ram_cs   = i_vga_cs;
        o_ram_we   = 1'b0;
        if (state == CPU_CYCLE) begin
            o_ram_addr = hold_addr;
            o_ram_dat  = hold_dat;
            o_ram_cs   = 1'b1;
            o_ram_we   = hold_we;
        end
    end

    // The synchronous RAM returns read data in ACK, so it is forwarded with the ack.
    assign o_cpu_ack  = (state == ACK);
    assign o_cpu_dat  = (o_cpu_ack && !hold_we) ? i_ram_dat : cpu_dat_q;
    assign o_vga_dat  = i_ram_dat;
    assign o_conflict = conflict_q;

endmodule : vgaram_arbiter

// File: doc/vgaram_arbiter.md
# vgaram_arbiter

Single-port video RAM arbiter sitting between the monochrome text controller (VGA read master) and the CPU bus. VGA reads have absolute priority and are announced one cycle ahead via the VGA access-request line. CPU reads and writes are queued, issued only in cycles the VGA master does not use, and completed with a one-cycle ack pulse.

## Interface
Parameters:
- AW, 16, RAM address width
- DW, 8, RAM data width

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_vga_addr  in  AW  VGA read address
- i_vga_cs  in  1  VGA owns the RAM port this cycle (read)
- i_vga_access  in  1  VGA will assert i_vga_cs next cycle
- o_vga_dat  out  DW  read data to VGA; wired to i_ram_dat
- i_cpu_addr  in  AW  CPU address
- i_cpu_dat  in  DW  CPU write data
- i_cpu_cs  in  1  CPU request, held until ack
- i_cpu_we  in  1  1 = write, 0 = read
- o_cpu_dat  out  DW  CPU read data, valid with ack, held until next ack
- o_cpu_ack  out  1  one-cycle completion pulse
- o_ram_addr  out  AW  RAM address
- o_ram_dat  out  DW  RAM write data
- o_ram_cs  out  1  RAM select
- o_ram_we  out  1  RAM write enable
- i_ram_dat  in  DW  RAM read data, valid the cycle after address (synchronous RAM)
- o_conflict  out  1  sticky error: VGA selected during a CPU cycle

## Operation
- Protocol invariant from the VGA master: i_vga_access(t) == i_vga_cs(t+1).
- FSM states:
  - IDLE: if i_cpu_cs && !i_vga_access, latch addr/dat/we into holding registers and go to CPU_CYCLE. Otherwise stay.
  - CPU_CYCLE: RAM port driven from the holding registers (cs=1, we=latched we). Always go to ACK next.
  - ACK: o_cpu_ack=1. For a read, capture i_ram_dat into o_cpu_dat. Always go to IDLE. i_cpu_cs is ignored in this state.
- RAM mux: in CPU_CYCLE the RAM port is driven by the CPU holding registers. In all other states o_ram_addr=i_vga_addr, o_ram_cs=i_vga_cs, o_ram_we=0, o_ram_dat=0.
- Writes commit in CPU_CYCLE. The ack follows one cycle later, and o_cpu_dat is unchanged on a write ack.
- o_conflict is set when i_vga_cs=1 in CPU_CYCLE. It is cleared only by reset. The CPU cycle still completes; VGA data in that cycle is unspecified.
- The CPU must hold i_cpu_cs/addr/dat/we stable until ack. It may drop the request or present a new one the cycle after ack.
- Simultaneous i_cpu_cs and i_vga_access in IDLE: the CPU waits, with no state change.

## Timing
- Reset values: state IDLE, o_cpu_ack 0, o_cpu_dat 0, o_conflict 0, holding registers 0.
- Because reset is synchronous, the RAM mux still follows the pre-reset state during the reset cycle. From the next cycle, o_ram_cs/o_ram_we follow the VGA inputs.
- Reset in CPU_CYCLE: a write already issued that cycle commits, and no ack is issued.
- Reset in ACK: the ack is visible that cycle, then the FSM goes to IDLE.
- Best-case CPU latency: request at t (IDLE, access=0) -> RAM cycle at t+1 -> ack at t+2.
- Minimum spacing is 3 cycles per CPU access.
- VGA access runs are 2 cycles long, so worst-case wait is 2 extra cycles, giving ack at t+4.
- VGA read latency is untouched: combinational path i_vga_* -> o_ram_* and i_ram_dat -> o_vga_dat. The only added logic is the 2:1 mux gated by the registered state.
- No combinational path from i_cpu_* to o_ram_*; the CPU side is fully registered.

## Structure
- Shared package vgaram_pkg:
  - state enum (IDLE, CPU_CYCLE, ACK)
  - AW/DW defaults
- Single module; no sub-module is natural. The FSM, holding registers and output mux fit in one block of roughly 150 lines.

## Test plan
- CPU read at 0x1234, VGA idle, RAM returns 0x5A -> o_ram_cs/addr=0x1234 at t+1, ack with o_cpu_dat=0x5A at t+2.
- CPU write 0xC3 to 0x0010 -> o_ram_we=1, o_ram_dat=0xC3 at t+1; ack at t+2; o_cpu_dat unchanged.
- CPU request while i_vga_access=1 for 2 cycles -> VGA addresses pass through untouched; CPU RAM cycle starts right after; ack at t+4.
- Run the text controller scanline pattern (access on x[2:0]=4,5; cs on 5,6) with back-to-back CPU reads -> o_conflict stays 0; every VGA fetch returns the correct byte.
- Force i_vga_cs=1 during CPU_CYCLE -> o_conflict=1 and stays set until i_reset.
- Assert reset in CPU_CYCLE of a write -> write commits, no ack, state IDLE and all outputs at reset values the next cycle.
